// File: rtl/servo_cmd_if.sv
// Button inputs and servo command outputs of servo_cmd, grouped as one bundle.
// The master side drives the buttons; the slave side (servo_cmd) drives the commands.
interface servo_cmd_if;
  logic btn_l;
  logic btn_r;
  logic l_ctrl;
  logic r_ctrl;
  logic conflict;

  modport master (output btn_l, btn_r, input l_ctrl, r_ctrl, conflict);
  modport slave  (input btn_l, btn_r, output l_ctrl, r_ctrl, conflict);
endinterface

// File: rtl/servo_cmd.sv
// Two-button servo commander: synchronize and debounce each button, then arbitrate
// left/right moves with a lockout whenever both buttons are held.
module servo_cmd #(
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  servo_cmd_if.slave  bus
);

  localparam logic [15:0] LAST_TICK = 16'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_L,
    MOVE_R,
    LOCKOUT
  } state_e;

  // Index 0 is the left button, index 1 the right button.
  logic [1:0]  btn_raw;
  logic [1:0]  sync1_q;
  logic [1:0]  sync2_q;
  logic [1:0]  db_q;
  logic [1:0]  db_d;
  logic [15:0] cnt_q [2];
  logic [15:0] cnt_d [2];

  state_e state_q;
  state_e state_d;
  logic   l_ctrl_q;
  logic   r_ctrl_q;
  logic   conflict_q;

  assign btn_raw = {bus.btn_r, bus.btn_l};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes the two-flop
  // synchronizer a real two-stage chain instead of a single wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // A level must disagree with db for DEBOUNCE_TICKS consecutive cycles to be taken.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = 16'd0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == LAST_TICK) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // NOTE: the counter array is a pair of plain registers, not a RAM, so it is
  // cleared by the async reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (db_q[0] && db_q[1])  state_d = LOCKOUT;
        else if (db_q[0])        state_d = MOVE_L;
        else if (db_q[1])        state_d = MOVE_R;
      end
      MOVE_L: begin
        if (db_q[1])             state_d = LOCKOUT;
        else if (!db_q[0])       state_d = IDLE;
      end
      MOVE_R: begin
        if (db_q[0])             state_d = LOCKOUT;
        else if (!db_q[1])       state_d = IDLE;
      end
      LOCKOUT: begin
        // Releasing only one button must not resume movement.
        if (!db_q[0] && !db_q[1]) state_d = IDLE;
      end
      default:                   state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      l_ctrl_q   <= 1'b0;
      r_ctrl_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      l_ctrl_q   <= (state_d == MOVE_L);
      r_ctrl_q   <= (state_d == MOVE_R);
      conflict_q <= (state_d == LOCKOUT);
    end
  end

  assign bus.l_ctrl   = l_ctrl_q;
  assign bus.r_ctrl   = r_ctrl_q;
  assign bus.conflict = conflict_q;

endmodule

// File: tb/tb_servo_cmd.sv
// Directed and random checks of servo_cmd with DEBOUNCE_TICKS=4, plus a second
// instance at DEBOUNCE_TICKS=1 for the minimum-latency boundary.
module tb_servo_cmd;

  localparam int T = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  servo_cmd_if bus ();
  servo_cmd_if bus1 ();

  assign bus1.btn_l = bus.btn_l;
  assign bus1.btn_r = bus.btn_r;

  servo_cmd #(.DEBOUNCE_TICKS(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  servo_cmd #(.DEBOUNCE_TICKS(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // {l_ctrl, r_ctrl, conflict}
  logic [2:0] outs;
  logic [2:0] outs1;
  assign outs  = {bus.l_ctrl, bus.r_ctrl, bus.conflict};
  assign outs1 = {bus1.l_ctrl, bus1.r_ctrl, bus1.conflict};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
  endtask

  // Advance one rising edge and land 1 time unit past it, away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.btn_l = 1'b0;
    bus.btn_r = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Random-phase bookkeeping
  int hold_l, hold_r;
  int stab_l, stab_r;
  int hl [4];
  int hr [4];
  logic prev_l, prev_r;
  logic [2:0] prev_outs;
  int excl_viol, stab_viol, n_changes;

  initial begin
    do_reset();
    check("reset_outs", outs, 3'b000);
    check("reset_outs_t1", outs1, 3'b000);

    // Left press: ctrl rises at edge T+3 (edge 4 for the T=1 instance).
    bus.btn_l = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("l_press_e%0d", e), outs, (e >= 7) ? 3'b100 : 3'b000);
      check($sformatf("l_press_t1_e%0d", e), outs1, (e >= 4) ? 3'b100 : 3'b000);
    end
    // Release latency is identical.
    bus.btn_l = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("l_rel_e%0d", e), outs, (e < 7) ? 3'b100 : 3'b000);
      check($sformatf("l_rel_t1_e%0d", e), outs1, (e < 4) ? 3'b100 : 3'b000);
    end

    // A 3-cycle glitch on the right button never makes it past the debouncer.
    bus.btn_r = 1'b1;
    for (int c = 0; c < 23; c++) begin
      if (c == 3) bus.btn_r = 1'b0;
      tick();
      check($sformatf("r_glitch_c%0d", c), outs, 3'b000);
    end

    // Left held, then right pressed: lockout; releasing right alone keeps it.
    bus.btn_l = 1'b1;
    repeat (7) tick();
    check("lr_left_active", outs, 3'b100);
    bus.btn_r = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("lr_lock_e%0d", e), outs, (e < 7) ? 3'b100 : 3'b001);
    end
    bus.btn_r = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("lr_hold_lock_c%0d", c), outs, 3'b001);
    end
    bus.btn_l = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("lr_unlock_e%0d", e), outs, (e < 7) ? 3'b001 : 3'b000);
    end

    // Both buttons rising together go straight to lockout, no move pulse.
    bus.btn_l = 1'b1;
    bus.btn_r = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("both_e%0d", e), outs, (e < 7) ? 3'b000 : 3'b001);
    end
    bus.btn_l = 1'b0;
    bus.btn_r = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("both_rel_e%0d", e), outs, (e < 7) ? 3'b001 : 3'b000);
    end

    // Async reset mid-move, then a button held through reset release is a new press.
    bus.btn_r = 1'b1;
    repeat (7) tick();
    check("rst_r_active", outs, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", outs, 3'b000);
    tick();
    check("rst_held_clear", outs, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check($sformatf("rst_repress_e%0d", e), outs, (e >= 7) ? 3'b010 : 3'b000);
    end

    // Random toggling: mutual exclusion and debounce stability on every change.
    do_reset();
    hold_l = 0; hold_r = 0;
    stab_l = 0; stab_r = 0;
    prev_l = 1'b0; prev_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hl[i] = 0;
      hr[i] = 0;
    end
    prev_outs = outs;
    excl_viol = 0; stab_viol = 0; n_changes = 0;
    for (int c = 0; c < 10000; c++) begin
      if (hold_l == 0) begin
        bus.btn_l = 1'($urandom_range(0, 1));
        hold_l    = int'($urandom_range(1, 10));
      end
      if (hold_r == 0) begin
        bus.btn_r = 1'($urandom_range(0, 1));
        hold_r    = int'($urandom_range(1, 10));
      end
      hold_l--;
      hold_r--;
      tick();
      // Run length of identical raw samples, ending at this edge.
      stab_l = (bus.btn_l == prev_l) ? stab_l + 1 : 1;
      stab_r = (bus.btn_r == prev_r) ? stab_r + 1 : 1;
      prev_l = bus.btn_l;
      prev_r = bus.btn_r;
      for (int i = 3; i > 0; i--) begin
        hl[i] = hl[i-1];
        hr[i] = hr[i-1];
      end
      hl[0] = stab_l;
      hr[0] = stab_r;
      if ((bus.l_ctrl && bus.r_ctrl) || (bus1.l_ctrl && bus1.r_ctrl)) excl_viol++;
      // A change seen after edge k needs a raw run of >= T samples ending at edge k-3.
      if (outs != prev_outs) begin
        n_changes++;
        if (hl[3] < T && hr[3] < T) stab_viol++;
      end
      prev_outs = outs;
    end
    check("rand_exclusive", 3'(excl_viol > 0), 3'b000);
    check("rand_stable", 3'(stab_viol > 0), 3'b000);
    check("rand_activity", 3'(n_changes > 0), 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
